// File: rtl/icache_fetch_responder.sv
// Direct-mapped, one-word-per-line instruction cache responder for the fetch stage.
// Lookups are combinational; misses stall the PC and refill over a req/ack memory port.
module icache_fetch_responder #(
    parameter int INDEX_BITS = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_valid,
    input  logic [31:0]          fetch_addr,
    input  logic                 invalidate,
    output logic [31:0]          inst,
    output logic                 hit,
    output logic                 stall,
    output logic                 mem_req,
    output logic [31:0]          mem_addr,
    input  logic                 mem_ack,
    input  logic [31:0]          mem_rdata,
    output logic [CNT_WIDTH-1:0] hit_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} fsmState;
    fsmState state;

    logic [LINES-1:0]    validBits;
    logic [TAG_BITS-1:0] tagArr [LINES];
    logic [31:0]         dataArr [LINES];
    logic                invPending;

    logic [INDEX_BITS-1:0] lookupIdx, fillIdx;
    logic [TAG_BITS-1:0]   lookupTag, fillTag;
    logic                  miss, fillDone, keepLine;
    logic [LINES-1:0]      validAfterInv, fillMask;

    always_comb begin
        lookupIdx     = fetch_addr[INDEX_BITS+1:2];
        lookupTag     = fetch_addr[31:INDEX_BITS+2];
        fillIdx       = mem_addr[INDEX_BITS+1:2];
        fillTag       = mem_addr[31:INDEX_BITS+2];
        hit           = (state == IDLE) && fetch_valid && validBits[lookupIdx]
                        && (tagArr[lookupIdx] == lookupTag);
        inst          = hit ? dataArr[lookupIdx] : 32'h0;
        miss          = (state == IDLE) && fetch_valid && !hit;
        stall         = (fetch_valid && !hit) || (state == REQ);
        fillDone      = (state == REQ) && mem_ack;
        // An invalidate seen at any point of the refill, including the ack cycle, poisons the line.
        keepLine      = !(invPending || invalidate);
        validAfterInv = invalidate ? '0 : validBits;
        fillMask           = '0;
        fillMask[fillIdx]  = 1'b1;
    end

    // Memory handshake: mem_req rises the cycle after a miss and stays high with mem_addr
    // stable until a one-cycle mem_ack; the word transfers on the edge where both are high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= 32'h0;
            validBits  <= '0;
            invPending <= 1'b0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    validBits <= validAfterInv;
                    if (miss) begin
                        mem_addr <= fetch_addr & 32'hFFFF_FFFC;
                        mem_req  <= 1'b1;
                        state    <= REQ;
                        if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + CNT_WIDTH'(1);
                    end
                    if (hit && (hit_cnt != CNT_MAX)) hit_cnt <= hit_cnt + CNT_WIDTH'(1);
                end
                REQ: begin
                    if (mem_ack) begin
                        validBits  <= keepLine ? (validAfterInv | fillMask)
                                               : (validAfterInv & ~fillMask);
                        invPending <= 1'b0;
                        mem_req    <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        validBits  <= validAfterInv;
                        invPending <= invPending | invalidate;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data carry no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (!rst && fillDone) begin
            tagArr[fillIdx]  <= fillTag;
            dataArr[fillIdx] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Bench for icache_fetch_responder: directed table, corner-case sequences and random traffic
// against a line-array reference model; a second instance checks 4-bit counter saturation.
module tb_icache_fetch_responder;
    localparam int IB = 4;

    logic        clk = 1'b0;
    logic        rst, fetch_valid, invalidate, mem_ack;
    logic [31:0] fetch_addr, mem_rdata;
    logic [31:0] inst, mem_addr, hit_cnt, miss_cnt;
    logic        hit, stall, mem_req;
    logic [31:0] inst4, memAddr4;
    logic        hit4, stall4, memReq4;
    logic [3:0]  hitCnt4, missCnt4;

    icache_fetch_responder #(.INDEX_BITS(IB), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
        .invalidate(invalidate), .inst(inst), .hit(hit), .stall(stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    icache_fetch_responder #(.INDEX_BITS(IB), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
        .invalidate(invalidate), .inst(inst4), .hit(hit4), .stall(stall4),
        .mem_req(memReq4), .mem_addr(memAddr4), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_cnt(hitCnt4), .miss_cnt(missCnt4)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int nChecks = 0;
    int nFails  = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void failNote(string name);
        nChecks++;
        nFails++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endfunction

    // ---------------- reference model ----------------
    logic        mV [1<<IB];
    logic [29-IB:0] mT [1<<IB];
    logic [31:0] mD [1<<IB];
    logic        mBusy, mInvPend;
    logic [31:0] mAddr;
    longint      mHits, mMisses;
    logic [31:0] expQ[$];
    logic [31:0] memSalt;

    logic        lastHit, lastStall, lastReq;
    logic [31:0] lastInst, lastAddr, lastHc, lastMc;

    function automatic logic [31:0] sat(longint v, int w);
        longint mx = (longint'(1) << w) - 1;
        longint r  = (v > mx) ? mx : v;
        return r[31:0];
    endfunction

    function automatic logic modelHit(logic fv, logic [31:0] fa);
        logic [IB-1:0] i = fa[IB+1:2];
        return !mBusy && fv && mV[i] && (mT[i] == fa[31:IB+2]);
    endfunction

    function automatic logic [31:0] memWord(logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]} ^ memSalt;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < (1 << IB); i++) mV[i] = 1'b0;
        mBusy = 1'b0; mInvPend = 1'b0; mAddr = 32'h0; mHits = 0; mMisses = 0;
    endfunction

    function automatic void modelStep(logic fv, logic [31:0] fa, logic inv, logic ack,
                                      logic [31:0] rd, logic r);
        logic h;
        logic [IB-1:0] fi;
        if (r) begin
            modelReset();
        end else if (!mBusy) begin
            h = modelHit(fv, fa);
            if (inv) for (int i = 0; i < (1 << IB); i++) mV[i] = 1'b0;
            if (fv && !h) begin
                mBusy = 1'b1;
                mAddr = {fa[31:2], 2'b00};
                mMisses++;
                expQ.push_back(mAddr);
            end else if (h) begin
                mHits++;
            end
        end else begin
            if (inv) begin
                for (int i = 0; i < (1 << IB); i++) mV[i] = 1'b0;
                mInvPend = 1'b1;
            end
            if (ack) begin
                fi = mAddr[IB+1:2];
                mV[fi] = !mInvPend;
                mT[fi] = mAddr[31:IB+2];
                mD[fi] = rd;
                mBusy = 1'b0;
                mInvPend = 1'b0;
            end
        end
    endfunction

    // ---------------- driver ----------------
    task automatic cycle(input logic fv, input logic [31:0] fa, input logic inv,
                         input logic ack, input logic [31:0] rd, input logic r);
        logic eh;
        logic [IB-1:0] i;
        rst = r; fetch_valid = fv; fetch_addr = fa; invalidate = inv;
        mem_ack = ack; mem_rdata = rd;
        #1;
        eh = modelHit(fv, fa);
        i  = fa[IB+1:2];
        lastHit = hit; lastStall = stall; lastReq = mem_req; lastInst = inst;
        lastAddr = mem_addr; lastHc = hit_cnt; lastMc = miss_cnt;
        check("hit", 32'(hit), 32'(eh));
        check("inst", inst, eh ? mD[i] : 32'h0);
        check("stall", 32'(stall), 32'((fv && !eh) || mBusy));
        check("mem_req", 32'(mem_req), 32'(mBusy));
        check("mem_addr", mem_addr, mAddr);
        check("hit_cnt", hit_cnt, sat(mHits, 32));
        check("miss_cnt", miss_cnt, sat(mMisses, 32));
        check("hit_cnt4", 32'(hitCnt4), sat(mHits, 4));
        check("miss_cnt4", 32'(missCnt4), sat(mMisses, 4));
        modelStep(fv, fa, inv, ack, rd, r);
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    // Memory responder that acks `lat` cycles into the request; ends on the first hit.
    task automatic fetchUntilHit(input logic [31:0] a, input int lat, output logic [31:0] reqAddr);
        int   age  = 0;
        logic done = 1'b0;
        logic ackv;
        reqAddr = 32'hFFFF_FFFF;
        for (int n = 0; n < 40 && !done; n++) begin
            done = modelHit(1'b1, a);
            ackv = mBusy && (age == lat);
            if (mBusy) begin
                reqAddr = mem_addr;
                age++;
            end else begin
                age = 0;
            end
            cycle(1'b1, a, 1'b0, ackv, memWord(mAddr), 1'b0);
        end
        if (!done) failNote("fetch_timeout");
    endtask

    task automatic randomPhase(input int n);
        int age = 0;
        int lat = 0;
        logic fv, inv, ack, r;
        logic [31:0] a;
        for (int k = 0; k < n; k++) begin
            fv  = ($urandom_range(0, 3) != 0);
            a   = ($urandom_range(0, 3) << (IB + 2)) | ($urandom_range(0, (1 << IB) - 1) << 2)
                  | $urandom_range(0, 3);
            inv = ($urandom_range(0, 39) == 0);
            r   = ($urandom_range(0, 299) == 0);
            if (mBusy) begin
                ack = (age >= lat);
                age++;
            end else begin
                ack = ($urandom_range(0, 7) == 0);
                age = 0;
                lat = $urandom_range(0, 4);
            end
            cycle(fv, a, inv, ack, $urandom, r);
        end
    endtask

    // ---------------- scoreboard: order of memory requests ----------------
    logic reqPrev = 1'b0;
    always @(negedge clk) begin
        if (mem_req && !reqPrev) begin
            if (expQ.size() == 0) failNote("unexpected_mem_req");
            else check("req_order", mem_addr, expQ.pop_front());
        end
        reqPrev = mem_req;
    end

    // ---------------- directed table ----------------
    typedef struct {
        logic        fv;
        logic        ack;
        logic [31:0] rd;
        logic        eHit;
        logic [31:0] eInst;
        logic        eStall;
        logic        eReq;
        logic [31:0] eHc;
        logic [31:0] eMc;
    } vecT;
    vecT vecs[$];

    function automatic void addVec(logic fv, logic ack, logic [31:0] rd, logic eHit,
                                   logic [31:0] eInst, logic eStall, logic eReq,
                                   logic [31:0] eHc, logic [31:0] eMc);
        vecT v;
        v.fv = fv; v.ack = ack; v.rd = rd; v.eHit = eHit; v.eInst = eInst;
        v.eStall = eStall; v.eReq = eReq; v.eHc = eHc; v.eMc = eMc;
        vecs.push_back(v);
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] ra;
        rst = 1'b1; fetch_valid = 1'b0; fetch_addr = 32'h0; invalidate = 1'b0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        memSalt = $urandom;
        modelReset();
        @(posedge clk);
        #1;

        // Cold miss on 0x0, ack three cycles after mem_req, then a run of hits.
        addVec(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < 3; k++)
            addVec(1'b1, 1'b0, 32'h0,     1'b0, 32'h0,         1'b1, 1'b1, 32'd0, 32'd1);
        addVec(1'b1, 1'b1, 32'h20010005,  1'b0, 32'h0,         1'b1, 1'b1, 32'd0, 32'd1);
        for (int k = 0; k < 5; k++)
            addVec(1'b1, 1'b0, 32'h0,     1'b1, 32'h20010005,  1'b0, 1'b0, 32'(k), 32'd1);
        addVec(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'd5, 32'd1);
        for (int k = 0; k < vecs.size(); k++) begin
            cycle(vecs[k].fv, 32'h0, 1'b0, vecs[k].ack, vecs[k].rd, 1'b0);
            check($sformatf("t1_hit_%0d", k),   32'(lastHit),   32'(vecs[k].eHit));
            check($sformatf("t1_inst_%0d", k),  lastInst,       vecs[k].eInst);
            check($sformatf("t1_stall_%0d", k), 32'(lastStall), 32'(vecs[k].eStall));
            check($sformatf("t1_req_%0d", k),   32'(lastReq),   32'(vecs[k].eReq));
            check($sformatf("t1_addr_%0d", k),  lastAddr,       32'h0);
            check($sformatf("t1_hc_%0d", k),    lastHc,         vecs[k].eHc);
            check($sformatf("t1_mc_%0d", k),    lastMc,         vecs[k].eMc);
        end

        // Conflict: 0x4 and 0x44 share an index.
        resetDut();
        fetchUntilHit(32'h4, 1, ra);
        check("t2_addr_4", ra, 32'h4);
        fetchUntilHit(32'h44, 2, ra);
        check("t2_addr_44", ra, 32'h44);
        fetchUntilHit(32'h4, 0, ra);
        check("t2_refetch_addr", ra, 32'h4);
        check("t2_miss_cnt", miss_cnt, 32'd3);

        // Branch redirect while a refill is outstanding.
        resetDut();
        cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t3_req", 32'(mem_req), 32'd1);
        check("t3_addr", mem_addr, 32'h10);
        cycle(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t3_addr_hold", mem_addr, 32'h10);
        cycle(1'b1, 32'h80, 1'b0, 1'b1, memWord(32'h10), 1'b0);
        check("t3_req_drop", 32'(mem_req), 32'd0);
        cycle(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t3_new_miss", 32'(lastHit), 32'd0);
        check("t3_req_again", 32'(mem_req), 32'd1);
        check("t3_addr_80", mem_addr, 32'h80);
        fetchUntilHit(32'h80, 1, ra);
        cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t3_old_hit", 32'(lastHit), 32'd1);
        check("t3_old_inst", lastInst, memWord(32'h10));

        // Invalidate in IDLE, during a refill, and alongside a lookup.
        resetDut();
        fetchUntilHit(32'h0, 1, ra);
        fetchUntilHit(32'h4, 2, ra);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t4_miss_0", 32'(lastHit), 32'd0);
        check("t4_stall_0", 32'(lastStall), 32'd1);
        fetchUntilHit(32'h0, 0, ra);
        cycle(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t4_miss_4", 32'(lastHit), 32'd0);
        fetchUntilHit(32'h4, 0, ra);
        cycle(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h8, 1'b0, 1'b1, memWord(32'h8), 1'b0);
        cycle(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t4_req_inv_miss", 32'(lastHit), 32'd0);
        check("t4_req_inv_req", 32'(mem_req), 32'd1);
        fetchUntilHit(32'h8, 1, ra);
        cycle(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 1'b0);
        check("t4_same_cycle_hit", 32'(lastHit), 32'd1);
        cycle(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t4_after_clear", 32'(lastHit), 32'd0);

        // Reset in the middle of a refill, with a late ack.
        resetDut();
        fetchUntilHit(32'h40, 0, ra);
        cycle(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 1'b1);
        check("t5_req", 32'(mem_req), 32'd0);
        check("t5_addr", mem_addr, 32'h0);
        check("t5_hc", hit_cnt, 32'd0);
        check("t5_mc", miss_cnt, 32'd0);
        cycle(1'b0, 32'h20, 1'b0, 1'b1, memWord(32'h20), 1'b0);
        check("t5_ack_ignored", 32'(mem_req), 32'd0);
        cycle(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t5_first_miss", 32'(lastHit), 32'd0);
        check("t5_first_stall", 32'(lastStall), 32'd1);
        check("t5_mc_after", miss_cnt, 32'd1);

        // Saturation of the narrow counters.
        resetDut();
        fetchUntilHit(32'h0, 0, ra);
        for (int k = 0; k < 20; k++) cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t6_hit_cnt4_sat", 32'(hitCnt4), 32'hF);
        check("t6_hit_cnt32", hit_cnt, 32'd21);

        // Random traffic against the model.
        resetDut();
        memSalt = $urandom;
        randomPhase(3000);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("req_queue_drained", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
